// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write path.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO of register-file write requests for the long-latency path.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  rf_wr_req_t             i_push_req,
  input  logic                   i_pop,
  output rf_wr_req_t             o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  rf_wr_req_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (o_count == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_head  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   o_count <= o_count + (AW+1)'(1);
        2'b01:   o_count <= o_count - (AW+1)'(1);
        default: o_count <= o_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_push_req;
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// Merges WB and long-latency write sources onto the single register-file
// write port and tracks registers still awaiting long-latency results.
module rf_write_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wb_valid,
  input  logic [rf_pkg::REG_ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]               i_wb_data,
  input  logic                          i_ls_valid,
  output logic                          o_ls_ready,
  input  logic [rf_pkg::REG_ADDR_W-1:0] i_ls_addr,
  input  logic [XLEN-1:0]               i_ls_data,
  input  logic                          i_issue_valid,
  input  logic [rf_pkg::REG_ADDR_W-1:0] i_issue_addr,
  input  logic [rf_pkg::REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [rf_pkg::REG_ADDR_W-1:0] i_rs2_addr,
  output logic                          o_rs1_busy,
  output logic                          o_rs2_busy,
  output logic                          o_rd_wren,
  output logic [rf_pkg::REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]        o_fifo_count
);

  import rf_pkg::*;

  rf_wr_req_t          fifo_push_req;
  rf_wr_req_t          fifo_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                wb_sel;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  assign o_ls_ready    = ~fifo_full;
  // x0 writes complete the handshake but are dropped here.
  assign fifo_push     = i_ls_valid & o_ls_ready & (i_ls_addr != '0);
  assign fifo_push_req = '{addr: i_ls_addr, data: i_ls_data};
  assign wb_sel        = i_wb_valid & (i_wb_addr != '0);
  assign fifo_pop      = ~wb_sel & ~fifo_empty;

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (fifo_push),
    .i_push_req (fifo_push_req),
    .i_pop      (fifo_pop),
    .o_head     (fifo_head),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_count    (o_fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else if (wb_sel) begin
      o_rd_wren <= 1'b1;
      o_rd_addr <= i_wb_addr;
      o_rd_data <= i_wb_data;
    end else if (fifo_pop) begin
      o_rd_wren <= 1'b1;
      o_rd_addr <= fifo_head.addr;
      o_rd_data <= fifo_head.data;
    end else begin
      o_rd_wren <= 1'b0;
    end
  end

  // Set is applied after clear so a same-edge issue to the popped register wins.
  always_comb begin
    pending_nxt = pending;
    if (fifo_pop) pending_nxt[fifo_head.addr] = 1'b0;
    if (i_issue_valid && (i_issue_addr != '0)) pending_nxt[i_issue_addr] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pending <= '0;
    else          pending <= pending_nxt;
  end

  // The register file reads the old value while a write is in flight.
  assign o_rs1_busy = (i_rs1_addr != '0) &
                      (pending[i_rs1_addr] | (o_rd_wren & (o_rd_addr == i_rs1_addr)));
  assign o_rs2_busy = (i_rs2_addr != '0) &
                      (pending[i_rs2_addr] | (o_rd_wren & (o_rd_addr == i_rs2_addr)));

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed scenarios plus random traffic against a queue-based model of the write controller.
module tb_rf_write_ctrl;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_wb_valid;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ls_valid;
  logic        o_ls_ready;
  logic [4:0]  i_ls_addr;
  logic [31:0] i_ls_data;
  logic        i_issue_valid;
  logic [4:0]  i_issue_addr;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_rs1_busy;
  logic        o_rs2_busy;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic [2:0]  o_fifo_count;

  always #5 i_clk = ~i_clk;

  rf_write_ctrl #(
    .DEPTH (DEPTH),
    .XLEN  (32)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wb_valid    (i_wb_valid),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .i_ls_valid    (i_ls_valid),
    .o_ls_ready    (o_ls_ready),
    .i_ls_addr     (i_ls_addr),
    .i_ls_data     (i_ls_data),
    .i_issue_valid (i_issue_valid),
    .i_issue_addr  (i_issue_addr),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy),
    .o_rd_wren     (o_rd_wren),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_fifo_count  (o_fifo_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  req_t        mq[$];
  logic [31:0] mpend;
  logic        m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_busy(input logic [4:0] rs);
    return (rs != 5'd0) && (mpend[rs] || (m_wren && m_addr == rs));
  endfunction

  task automatic model_reset();
    mq.delete();
    mpend  = '0;
    m_wren = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock edge of the controller, written from the source-merging rules.
  task automatic model_edge();
    req_t r;
    int   sz;
    sz = mq.size();
    if (i_wb_valid && i_wb_addr != 5'd0) begin
      m_wren = 1'b1;
      m_addr = i_wb_addr;
      m_data = i_wb_data;
    end else if (sz > 0) begin
      r = mq.pop_front();
      m_wren = 1'b1;
      m_addr = r.addr;
      m_data = r.data;
      mpend[r.addr] = 1'b0;
    end else begin
      m_wren = 1'b0;
    end
    if (i_ls_valid && sz != DEPTH && i_ls_addr != 5'd0) begin
      r.addr = i_ls_addr;
      r.data = i_ls_data;
      mq.push_back(r);
    end
    if (i_issue_valid && i_issue_addr != 5'd0) mpend[i_issue_addr] = 1'b1;
  endtask

  task automatic idle();
    i_wb_valid    = 1'b0;
    i_wb_addr     = '0;
    i_wb_data     = '0;
    i_ls_valid    = 1'b0;
    i_ls_addr     = '0;
    i_ls_data     = '0;
    i_issue_valid = 1'b0;
    i_issue_addr  = '0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    check("ls_ready",   32'(o_ls_ready),   32'(mq.size() != DEPTH));
    check("fifo_count", 32'(o_fifo_count), mq.size());
    check("rs1_busy",   32'(o_rs1_busy),   32'(exp_busy(i_rs1_addr)));
    check("rs2_busy",   32'(o_rs2_busy),   32'(exp_busy(i_rs2_addr)));
    @(posedge i_clk);
    model_edge();
    #1;
    check("rd_wren", 32'(o_rd_wren), 32'(m_wren));
    check("rd_addr", 32'(o_rd_addr), 32'(m_addr));
    check("rd_data", o_rd_data, m_data);
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0;
    idle();
    i_rs1_addr = '0;
    i_rs2_addr = '0;
    model_reset();
    #12;
    check("rst_wren",  32'(o_rd_wren),    32'd0);
    check("rst_addr",  32'(o_rd_addr),    32'd0);
    check("rst_data",  o_rd_data,         32'd0);
    check("rst_count", 32'(o_fifo_count), 32'd0);
    check("rst_ready", 32'(o_ls_ready),   32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Primary write and the idle cycle behind it
    i_wb_valid = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEADBEEF;
    step();
    check("t1_wren", 32'(o_rd_wren), 32'd1);
    check("t1_addr", 32'(o_rd_addr), 32'd5);
    check("t1_data", o_rd_data,      32'hDEADBEEF);
    idle();
    step();
    check("t1_idle_wren", 32'(o_rd_wren), 32'd0);

    // Long-latency write to x7 with its scoreboard bit
    i_issue_valid = 1'b1; i_issue_addr = 5'd7; i_rs1_addr = 5'd7;
    step();
    check("t2_busy_pend", 32'(o_rs1_busy), 32'd1);
    idle();
    i_ls_valid = 1'b1; i_ls_addr = 5'd7; i_ls_data = 32'h1234;
    step();
    idle();
    step();
    check("t2_pop_addr", 32'(o_rd_addr),  32'd7);
    check("t2_pop_data", o_rd_data,       32'h1234);
    check("t2_busy_wr",  32'(o_rs1_busy), 32'd1);
    step();
    check("t2_busy_clr", 32'(o_rs1_busy), 32'd0);

    // Fill the FIFO behind continuous WB traffic, then drain in order
    for (int k = 1; k <= 4; k++) begin
      i_wb_valid = 1'b1; i_wb_addr = 5'd20; i_wb_data = 32'hA000 + k;
      i_ls_valid = 1'b1; i_ls_addr = 5'(k); i_ls_data = 32'hB000 + k;
      step();
    end
    i_ls_addr = 5'd6;
    #1;
    check("t3_full_count", 32'(o_fifo_count), 32'd4);
    check("t3_full_ready", 32'(o_ls_ready),   32'd0);
    step();
    idle();
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t3_drain_addr", 32'(o_rd_addr), k);
      check("t3_drain_data", o_rd_data,      32'hB000 + k);
    end
    check("t3_empty", 32'(o_fifo_count), 32'd0);

    // x0 on both sources
    i_wb_valid = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h5555;
    i_ls_valid = 1'b1; i_ls_addr = 5'd0; i_ls_data = 32'h6666;
    i_issue_valid = 1'b1; i_issue_addr = 5'd0; i_rs1_addr = 5'd0;
    step();
    check("t4_wren",  32'(o_rd_wren),    32'd0);
    check("t4_count", 32'(o_fifo_count), 32'd0);
    check("t4_busy0", 32'(o_rs1_busy),   32'd0);
    idle();
    step();

    // Re-issue of x9 on the edge its FIFO entry pops
    i_issue_valid = 1'b1; i_issue_addr = 5'd9; i_rs2_addr = 5'd9;
    i_ls_valid = 1'b1; i_ls_addr = 5'd9; i_ls_data = 32'hAAAA;
    step();
    i_ls_valid = 1'b0;
    step();
    check("t5_pop_addr", 32'(o_rd_addr), 32'd9);
    idle();
    step();
    check("t5_hold_busy", 32'(o_rs2_busy), 32'd1);
    i_ls_valid = 1'b1; i_ls_addr = 5'd9; i_ls_data = 32'hBBBB;
    step();
    idle();
    step();
    check("t5_second_data", o_rd_data, 32'hBBBB);
    step();
    check("t5_busy_clr", 32'(o_rs2_busy), 32'd0);

    // Reset with live FIFO contents and a pending register
    i_issue_valid = 1'b1; i_issue_addr = 5'd3;
    step();
    i_issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_wb_valid = 1'b1; i_wb_addr = 5'd20; i_wb_data = 32'hC000 + k;
      i_ls_valid = 1'b1; i_ls_addr = 5'(10 + k); i_ls_data = 32'hD000 + k;
      step();
    end
    idle();
    i_rs1_addr = 5'd3; i_rs2_addr = 5'd20;
    i_rst_n = 1'b0;
    #1;
    check("t6_wren",  32'(o_rd_wren),    32'd0);
    check("t6_count", 32'(o_fifo_count), 32'd0);
    check("t6_ready", 32'(o_ls_ready),   32'd1);
    check("t6_busy1", 32'(o_rs1_busy),   32'd0);
    check("t6_busy2", 32'(o_rs2_busy),   32'd0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();

    // Random traffic in phases of heavy, medium and light WB load
    for (int i = 0; i < 3000; i++) begin
      int wb_pct;
      case ((i / 300) % 3)
        0:       wb_pct = 90;
        1:       wb_pct = 50;
        default: wb_pct = 10;
      endcase
      i_wb_valid    = ($urandom_range(0, 99) < wb_pct);
      i_wb_addr     = 5'($urandom_range(0, 31));
      i_wb_data     = $urandom;
      i_ls_valid    = ($urandom_range(0, 99) < 60);
      i_ls_addr     = 5'($urandom_range(0, 31));
      i_ls_data     = $urandom;
      i_issue_valid = ($urandom_range(0, 99) < 30);
      i_issue_addr  = 5'($urandom_range(0, 31));
      i_rs1_addr    = 5'($urandom_range(0, 31));
      i_rs2_addr    = 5'($urandom_range(0, 31));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_write_ctrl.md
Name: rf_write_ctrl

Overview:
- Writer-side controller for the 32x32 register file write port (wren/addr/data) in the non-forwarding pipeline.
- Merges two write sources into the single write port: the in-order WB stage and a long-latency load/store/MUL response path.
- Buffers the long-latency source in a small FIFO.
- Keeps a pending-write scoreboard so the ID stage can stall on registers still awaiting long-latency results.

Parameters:
- DEPTH, 4, entries in the secondary-source FIFO; power of two, >= 2.
- XLEN, 32, data width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wb_valid  in  1  primary WB write request; always accepted, no ready.
- i_wb_addr  in  5  primary destination register.
- i_wb_data  in  XLEN  primary write data.
- i_ls_valid  in  1  secondary write request.
- o_ls_ready  out  1  secondary accept; transfer occurs when valid & ready.
- i_ls_addr  in  5  secondary destination register.
- i_ls_data  in  XLEN  secondary write data.
- i_issue_valid  in  1  long-latency op issued; marks its destination register pending.
- i_issue_addr  in  5  destination of the issued op.
- i_rs1_addr  in  5  ID-stage source 1 query.
- i_rs2_addr  in  5  ID-stage source 2 query.
- o_rs1_busy  out  1  source 1 must stall.
- o_rs2_busy  out  1  source 2 must stall.
- o_rd_wren  out  1  register file write enable (registered).
- o_rd_addr  out  5  register file write address (registered).
- o_rd_data  out  XLEN  register file write data (registered).
- o_fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous and active-low: o_rd_wren=0, o_rd_addr=0, o_rd_data=0, FIFO empty, o_fifo_count=0, pending vector all 0. o_ls_ready=1 after reset because the FIFO is empty.
- Output stage: o_rd_* are registered, one cycle after selection. When nothing is selected, o_rd_wren=0 and o_rd_addr/o_rd_data hold their previous values.
- Selection each cycle, primary has strict priority:
  - If i_wb_valid and i_wb_addr!=0: emit the WB request next cycle; the FIFO head waits.
  - Else if the FIFO is non-empty: pop the head and emit it next cycle.
  - Else: nothing is emitted.
- x0 handling:
  - A primary request to addr 0 is treated as no request, so the FIFO may drain that cycle.
  - A secondary request to addr 0 is accepted (ready honoured) and discarded, not enqueued.
  - An issue to addr 0 is ignored.
- FIFO:
  - o_ls_ready = (count != DEPTH), a function of registered count only. No same-cycle pass-through.
  - Simultaneous push and pop: count is unchanged. This is legal when full because ready is already low.
  - Read and write pointers wrap modulo DEPTH. Order is strictly preserved.
- Scoreboard, 32-bit pending vector:
  - Bit set at the edge where i_issue_valid is sampled.
  - Bit cleared at the edge where a FIFO-sourced entry with that address is popped (selected for output).
  - A primary write never clears a pending bit.
  - Same-cycle set and clear of the same address: set wins.
  - Re-issue to an already pending address keeps the bit set; it clears on the first matching pop. The issue logic must not issue two outstanding long ops to one register.
- Busy, combinational:
  - o_rsN_busy = (rsN!=0) & (pending[rsN] | (o_rd_wren & o_rd_addr==rsN)).
  - The second term covers the write-this-edge case, because the register file returns the old value during the write cycle.
- Mid-operation reset: FIFO contents and pending bits are lost. The pipeline is flushed by the same reset.

Decomposition:
- Shared package rf_pkg:
  - XLEN=32, REG_ADDR_W=5, NUM_REGS=32.
  - typedef rf_wr_req_t {logic [REG_ADDR_W-1:0] addr; logic [XLEN-1:0] data;}.
- One sub-module: rf_wr_fifo. It is a parameterised synchronous FIFO of rf_wr_req_t with push/pop/full/empty/count.
- Arbitration, scoreboard and output register stay in rf_write_ctrl.

Test Plan:
1. Reset then primary WB x5=0xDEADBEEF -> next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF. Following idle cycle o_rd_wren=0.
2. Issue x7, rs1=7 -> o_rs1_busy=1. ls write x7=0x1234 with no WB traffic -> pop next cycle, o_rd_* = x7/0x1234, busy held through the write cycle, 0 the cycle after.
3. Push 4 ls writes x1..x4 while WB writes every cycle -> o_ls_ready=0 at count=4. Stop WB -> x1..x4 drain in order on 4 consecutive cycles, o_fifo_count 4→0.
4. WB and ls to x0 -> o_rd_wren stays 0, ls handshake completes, o_fifo_count stays 0. rs1=0 -> o_rs1_busy=0.
5. Issue x9 on the same edge that FIFO entry x9 pops -> bit remains set, o_rs2_busy=1 (rs2=9) until a second x9 ls write drains.
6. Assert i_rst_n=0 with 3 FIFO entries and x3 pending -> immediately o_rd_wren=0, o_fifo_count=0, o_ls_ready=1, busy all 0.
